uart_rx: RTL and testbench

- Standalone UART receiver: converts asynchronous serial line `rx` into parallel words, using a fixed clocks-per-bit divider with mid-bit sampling.
- Frame: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, 1 stop bit (1).
- Delivers each received word through a one-deep holding register with a valid/ready handshake.
- Flags framing, parity and overrun errors; sits between the pad and the host-side command/data logic.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: fixed-divider UART receiver with mid-bit sampling, optional
// parity, a one-deep valid/ready holding register and one-cycle error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(H - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t state, state_n;

  logic                 rx_meta, rx_s;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  logic cnt_clr, shift_en, par_load, word_done, f_err, p_err, arm;
  logic tick_half, tick_full;

  assign tick_half = (baud_cnt == HALF_M1);
  assign tick_full = (baud_cnt == FULL_M1);

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    par_load  = 1'b0;
    word_done = 1'b0;
    f_err     = 1'b0;
    p_err     = 1'b0;
    arm       = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_clr = 1'b1;
          arm     = 1'b1;
        end
      end
      START: begin
        if (tick_half) begin
          cnt_clr = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_n = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick_full) begin
          cnt_clr  = 1'b1;
          par_load = 1'b1;
          state_n  = STOP;
        end
      end
      STOP: begin
        if (tick_full) begin
          cnt_clr = 1'b1;
          if (!rx_s) begin
            f_err   = 1'b1;
            state_n = WAIT_IDLE;
          end else if (par_bad) begin
            p_err   = 1'b1;
            state_n = IDLE;
          end else begin
            word_done = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Baud/bit counters, shift register and latched parity result.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      if (cnt_clr || state == IDLE || state == WAIT_IDLE) baud_cnt <= '0;
      else                                                 baud_cnt <= baud_cnt + 1'b1;
      if (arm) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end else begin
        if (shift_en) begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        end
        if (par_load) par_bad <= (rx_s != ((^shreg) ^ ODD));
      end
    end
  end

  // Holding register with valid/ready handshake, plus registered error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= f_err;
      parity_err <= p_err;
      overrun    <= 1'b0;
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; one default-parameter instance and
// one even-parity instance share clock and reset.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1, rxp = 1'b1;
  logic       ready = 1'b1, readyp = 1'b1;
  logic [7:0] data, datap;
  logic       valid, validp, ferr, ferrp, perr, perrp, ovr, ovrp;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fall_cyc = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(data), .rx_valid(valid),
    .rx_ready(ready), .frame_err(ferr), .parity_err(perr), .overrun(ovr));

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dutp (
    .clk(clk), .reset(reset), .rx(rxp), .rx_data(datap), .rx_valid(validp),
    .rx_ready(readyp), .frame_err(ferrp), .parity_err(perrp), .overrun(ovrp));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  int v_rise = 0, v_cyc = 0, v_hi = 0, f_hi = 0, f_cyc = 0, p_hi = 0, o_hi = 0, o_cyc = 0;
  int vp_rise = 0, fp_hi = 0, pp_hi = 0, op_hi = 0;
  logic [7:0] v_data = 8'h00, vp_data = 8'h00;
  logic prev_v = 1'b0, prev_vp = 1'b0;
  always @(negedge clk) begin
    if (valid && !prev_v) begin v_rise++; v_cyc = cyc; v_data = data; end
    if (valid) v_hi++;
    if (ferr) begin f_hi++; f_cyc = cyc; end
    if (perr) p_hi++;
    if (ovr) begin o_hi++; o_cyc = cyc; end
    if (validp && !prev_vp) begin vp_rise++; vp_data = datap; end
    if (ferrp) fp_hi++;
    if (perrp) pp_hi++;
    if (ovrp) op_hi++;
    prev_v  = valid;
    prev_vp = validp;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input bit sel, input logic b);
    if (sel) rxp = b; else rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    fall_cyc = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    checks++; if ({valid, ferr, perr, ovr} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b want 0000", {valid, ferr, perr, ovr}); end
    checks++; if (data !== 8'h00) begin errors++;
      $display("FAIL reset_data got %h want 00", data); end
    checks++; if ({validp, ferrp, perrp, ovrp, datap} !== 12'h000) begin errors++;
      $display("FAIL reset_par_dut got %h want 000", {validp, ferrp, perrp, ovrp, datap}); end
    reset = 1'b0;
    tick(5);
  endtask

  task automatic test_basic;
    int r0, h0, f0, p0, o0;
    r0 = v_rise; h0 = v_hi; f0 = f_hi; p0 = p_hi; o0 = o_hi;
    ready = 1'b1;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick(10);
    checks++; if (v_rise - r0 != 1) begin errors++;
      $display("FAIL basic_valid_count got %0d want 1", v_rise - r0); end
    checks++; if (v_cyc - fall_cyc != 155) begin errors++;
      $display("FAIL basic_latency got %0d want 155", v_cyc - fall_cyc); end
    checks++; if (v_data !== 8'hA5) begin errors++;
      $display("FAIL basic_data got %h want a5", v_data); end
    checks++; if (v_hi - h0 != 1) begin errors++;
      $display("FAIL basic_valid_width got %0d want 1", v_hi - h0); end
    checks++; if ((f_hi - f0) + (p_hi - p0) + (o_hi - o0) != 0) begin errors++;
      $display("FAIL basic_no_err got %0d want 0", (f_hi - f0) + (p_hi - p0) + (o_hi - o0)); end
  endtask

  task automatic test_false_start;
    int r0, f0, p0, o0;
    r0 = v_rise; f0 = f_hi; p0 = p_hi; o0 = o_hi;
    rx = 1'b0; tick(4);
    rx = 1'b1; tick(200);
    checks++; if ((v_rise - r0) + (f_hi - f0) + (p_hi - p0) + (o_hi - o0) != 0) begin errors++;
      $display("FAIL false_start_events got %0d want 0",
               (v_rise - r0) + (f_hi - f0) + (p_hi - p0) + (o_hi - o0)); end
  endtask

  task automatic test_break;
    int r0, f0;
    r0 = v_rise; f0 = f_hi;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    tick(40);
    rx = 1'b1; tick(20);
    checks++; if (f_hi - f0 != 1) begin errors++;
      $display("FAIL break_frame_err got %0d want 1", f_hi - f0); end
    checks++; if (f_cyc - fall_cyc != 155) begin errors++;
      $display("FAIL break_ferr_time got %0d want 155", f_cyc - fall_cyc); end
    checks++; if (v_rise - r0 != 0) begin errors++;
      $display("FAIL break_no_valid got %0d want 0", v_rise - r0); end
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    tick(10);
    checks++; if (v_rise - r0 != 1 || v_data !== 8'h81) begin errors++;
      $display("FAIL break_recover got %0d/%h want 1/81", v_rise - r0, v_data); end
  endtask

  task automatic test_back_to_back;
    int r0, o0;
    r0 = v_rise; o0 = o_hi;
    ready = 1'b0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    tick(10);
    checks++; if (valid !== 1'b1 || data !== 8'h3C) begin errors++;
      $display("FAIL b2b_hold got %b/%h want 1/3c", valid, data); end
    checks++; if (o_hi - o0 != 1) begin errors++;
      $display("FAIL b2b_overrun got %0d want 1", o_hi - o0); end
    checks++; if (o_cyc - fall_cyc != 155) begin errors++;
      $display("FAIL b2b_overrun_time got %0d want 155", o_cyc - fall_cyc); end
    checks++; if (v_rise - r0 != 1) begin errors++;
      $display("FAIL b2b_valid_count got %0d want 1", v_rise - r0); end
    ready = 1'b1; tick(1);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++;
      $display("FAIL b2b_drain got %b want 0", valid); end
    tick(5);
    ready = 1'b1;
  endtask

  task automatic test_parity;
    int r0, p0, f0;
    r0 = vp_rise; p0 = pp_hi; f0 = fp_hi;
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(10);
    checks++; if (vp_rise - r0 != 1 || vp_data !== 8'h07) begin errors++;
      $display("FAIL parity_ok got %0d/%h want 1/07", vp_rise - r0, vp_data); end
    checks++; if (pp_hi - p0 != 0) begin errors++;
      $display("FAIL parity_ok_no_err got %0d want 0", pp_hi - p0); end
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick(10);
    checks++; if (pp_hi - p0 != 1) begin errors++;
      $display("FAIL parity_bad_err got %0d want 1", pp_hi - p0); end
    checks++; if (vp_rise - r0 != 1 || fp_hi - f0 != 0) begin errors++;
      $display("FAIL parity_bad_excl got %0d/%0d want 1/0", vp_rise - r0, fp_hi - f0); end
  endtask

  task automatic test_reset_midframe;
    int r0, f0, p0, o0;
    ready = 1'b0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tick(10);
    checks++; if (valid !== 1'b1 || data !== 8'h5A) begin errors++;
      $display("FAIL midrst_pre got %b/%h want 1/5a", valid, data); end
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    tick(4);
    reset = 1'b1; tick(1); reset = 1'b0;
    checks++; if ({valid, ferr, perr, ovr} !== 4'b0 || data !== 8'h00) begin errors++;
      $display("FAIL midrst_clear got %b/%h want 0000/00", {valid, ferr, perr, ovr}, data); end
    r0 = v_rise; f0 = f_hi; p0 = p_hi; o0 = o_hi;
    ready = 1'b1;
    tick(CPB - 5);
    for (int i = 4; i < 8; i++) drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    tick(20);
    checks++; if ((v_rise - r0) + (f_hi - f0) + (p_hi - p0) + (o_hi - o0) != 0) begin errors++;
      $display("FAIL midrst_tail got %0d want 0",
               (v_rise - r0) + (f_hi - f0) + (p_hi - p0) + (o_hi - o0)); end
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    tick(10);
    checks++; if (v_rise - r0 != 1 || v_data !== 8'h55) begin errors++;
      $display("FAIL midrst_next got %0d/%h want 1/55", v_rise - r0, v_data); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_break;
    test_back_to_back;
    test_parity;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
